// File: rtl/adc_stream_framer.sv
// Buffers the tagged ADC word stream in a FWFT FIFO and emits framed AXI-Stream packets.
// Statistics outputs are built only when ADC_FRAMER_STATS_EN is defined.
module adc_stream_framer #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = 256
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  s_axis_tvalid,
    input  logic [31:0]           s_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [31:0]           m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  clear_stats,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic [31:0]           dropped_count,
    output logic [31:0]           packets_sent,
    output logic                  overflow
);

    localparam int                  DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [15:0]         LAST_BEAT  = 16'(MAX_BURST - 1);
    localparam logic [31:0]         END_WORD   = {2'b11, 30'd0};

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr_next;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic [31:0]           head;
    logic [31:0]           wr_data;
    logic [15:0]           beat;
    logic                  wr_en;
    logic                  drop;
    logic                  xfer;
    logic                  has_space;
    logic                  end_pending;
    logic                  end_pending_next;

    assign m_axis_tvalid = (count != '0);
    assign m_axis_tdata  = head;
    assign m_axis_tlast  = m_axis_tvalid && ((head[31:30] == 2'b11) || (beat == LAST_BEAT));
    assign fifo_count    = count;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    // A pending synthesized end marker takes the write slot ahead of the input.
    always_comb begin
        xfer      = m_axis_tvalid && m_axis_tready;
        has_space = (count != FULL_COUNT) || xfer;
        wr_en     = 1'b0;
        wr_data   = s_axis_tdata;
        drop      = 1'b0;
        if (end_pending && has_space) begin
            wr_en   = 1'b1;
            wr_data = END_WORD;
            drop    = s_axis_tvalid;
        end else if (s_axis_tvalid) begin
            if (has_space) begin
                wr_en = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
        end_pending_next = (end_pending && !has_space) ||
                           (drop && (s_axis_tdata[31:30] == 2'b11));
        rd_ptr_next = xfer ? rd_ptr + ADDR_WIDTH'(1) : rd_ptr;
        case ({wr_en, xfer})
            2'b10:   count_next = count + (ADDR_WIDTH+1)'(1);
            2'b01:   count_next = count - (ADDR_WIDTH+1)'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Head is prefetched from the next read address; a word landing on that
    // address this edge (FIFO about to hold one word) is forwarded directly.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            end_pending <= 1'b0;
            beat        <= '0;
            head        <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            rd_ptr      <= rd_ptr_next;
            count       <= count_next;
            end_pending <= end_pending_next;
            if (count_next != '0) begin
                head <= (wr_en && (wr_ptr == rd_ptr_next)) ? wr_data : mem[rd_ptr_next];
            end
            if (xfer) begin
                beat <= m_axis_tlast ? '0 : beat + 16'd1;
            end
        end
    end

`ifdef ADC_FRAMER_STATS_EN
    logic [31:0] dropped_q;
    logic [31:0] packets_q;
    logic        overflow_q;

    always_ff @(posedge aclk) begin
        if (areset || clear_stats) begin
            dropped_q  <= '0;
            packets_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
                if (dropped_q != '1) begin
                    dropped_q <= dropped_q + 32'd1;
                end
            end
            if (xfer && m_axis_tlast) begin
                packets_q <= packets_q + 32'd1;
            end
        end
    end

    assign dropped_count = dropped_q;
    assign packets_sent  = packets_q;
    assign overflow      = overflow_q;
`else
    logic unused_clear_stats;

    assign unused_clear_stats = clear_stats;
    assign dropped_count      = '0;
    assign packets_sent       = '0;
    assign overflow           = 1'b0;
`endif

endmodule

// File: tb/tb_adc_stream_framer.sv
// Randomized and directed bench for adc_stream_framer against a queue-based reference model.
// Statistics expectations follow ADC_FRAMER_STATS_EN as seen by this compilation.
module tb_adc_stream_framer;

    localparam int AW    = 3;
    localparam int MB    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef ADC_FRAMER_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic          aclk;
    logic          areset;
    logic          s_axis_tvalid;
    logic [31:0]   s_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tlast;
    logic          clear_stats;
    logic [AW:0]   fifo_count;
    logic [31:0]   dropped_count;
    logic [31:0]   packets_sent;
    logic          overflow;

    adc_stream_framer #(
        .ADDR_WIDTH(AW),
        .MAX_BURST (MB)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .clear_stats   (clear_stats),
        .fifo_count    (fifo_count),
        .dropped_count (dropped_count),
        .packets_sent  (packets_sent),
        .overflow      (overflow)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO contents, beat position within the current packet, stats.
    logic [31:0] q [$];
    bit          m_endp;
    int          m_beat;
    logic [31:0] m_drop;
    logic [31:0] m_pkts;
    bit          m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_last();
        logic [31:0] h;
        if (q.size() == 0) return 1'b0;
        h = q[0];
        return (h[31:30] == 2'b11) || (m_beat == MB - 1);
    endfunction

    task automatic model_step();
        bit          xfer, lst, room, drop, wr;
        logic [31:0] w;
        if (areset) begin
            q.delete();
            m_endp = 0; m_beat = 0; m_drop = '0; m_pkts = '0; m_ovf = 0;
            return;
        end
        lst  = model_last();
        xfer = (q.size() != 0) && m_axis_tready;
        room = (q.size() < DEPTH) || xfer;
        drop = 0; wr = 0; w = s_axis_tdata;
        if (m_endp && room) begin
            wr = 1; w = {2'b11, 30'd0}; drop = s_axis_tvalid; m_endp = 0;
        end else if (s_axis_tvalid) begin
            if (room) wr = 1;
            else drop = 1;
        end
        if (drop && s_axis_tdata[31:30] == 2'b11) m_endp = 1;
        if (xfer) begin
            void'(q.pop_front());
            m_beat = lst ? 0 : m_beat + 1;
        end
        if (wr) q.push_back(w);
        if (clear_stats) begin
            m_drop = '0; m_pkts = '0; m_ovf = 0;
        end else begin
            if (drop) begin
                m_ovf = 1;
                if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
            end
            if (xfer && lst) m_pkts = m_pkts + 1;
        end
    endtask

    task automatic compare_outputs();
        check("tvalid", 32'(m_axis_tvalid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("tdata", m_axis_tdata, q[0]);
            check("tlast", 32'(m_axis_tlast), 32'(model_last()));
        end else begin
            check("tlast_idle", 32'(m_axis_tlast), 32'd0);
        end
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
        check("dropped_count", dropped_count, STATS_EN ? m_drop : 32'd0);
        check("packets_sent", packets_sent, STATS_EN ? m_pkts : 32'd0);
        check("overflow", 32'(overflow), STATS_EN ? 32'(m_ovf) : 32'd0);
    endtask

    task automatic cycle();
        model_step();
        @(posedge aclk);
        #1;
        compare_outputs();
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input bit rdy);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        m_axis_tready = rdy;
        cycle();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, rdy);
    endtask

    function automatic logic [31:0] data_word(input int i);
        return {2'b10, 15'(i), 15'(i * 7 + 3)};
    endfunction

    initial begin
        areset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        m_axis_tready = 1'b0; clear_stats = 1'b0;
        cycle();
        cycle();
        areset = 1'b0;
        check("rst_tdata", m_axis_tdata, 32'd0);

        // Pass-through of a four-word series
        drive(1'b1, {2'b00, 30'h12}, 1'b1);
        drive(1'b1, {2'b01, 30'h34}, 1'b1);
        drive(1'b1, {2'b10, 15'd123, 15'd555}, 1'b1);
        drive(1'b1, {2'b11, 30'd0}, 1'b1);
        idle(3, 1'b1);
        check("pt_packets", packets_sent, STATS_EN ? 32'd1 : 32'd0);
        check("pt_count", 32'(fifo_count), 32'd0);

        // Burst split: ten data words then an end word
        for (int i = 0; i < 10; i++) drive(1'b1, data_word(i), 1'b1);
        drive(1'b1, {2'b11, 30'h1}, 1'b1);
        idle(3, 1'b1);
        check("burst_packets", packets_sent, STATS_EN ? 32'd4 : 32'd0);

        // Overflow with the output stalled
        clear_stats = 1'b1; idle(1, 1'b0); clear_stats = 1'b0;
        for (int i = 0; i < 12; i++) drive(1'b1, data_word(100 + i), 1'b0);
        check("ovf_count", 32'(fifo_count), 32'd8);
        check("ovf_dropped", dropped_count, STATS_EN ? 32'd4 : 32'd0);
        check("ovf_flag", 32'(overflow), STATS_EN ? 32'd1 : 32'd0);
        idle(10, 1'b1);

        // End marker dropped while full, then recovered
        for (int i = 0; i < 8; i++) drive(1'b1, data_word(200 + i), 1'b0);
        drive(1'b1, {2'b11, 30'h55}, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        check("endrec_count", 32'(fifo_count), 32'd8);
        idle(10, 1'b1);

        // Full FIFO with simultaneous read and write
        for (int i = 0; i < 8; i++) drive(1'b1, data_word(300 + i), 1'b0);
        drive(1'b1, data_word(308), 1'b1);
        check("full_rw_count", 32'(fifo_count), 32'd8);
        idle(12, 1'b1);

        // Reset with five words buffered and the beat counter at 2
        for (int i = 0; i < 7; i++) drive(1'b1, data_word(400 + i), 1'b0);
        idle(2, 1'b1);
        areset = 1'b1; idle(1, 1'b0); areset = 1'b0;
        check("rst_mid_valid", 32'(m_axis_tvalid), 32'd0);
        check("rst_mid_count", 32'(fifo_count), 32'd0);
        for (int i = 0; i < 6; i++) drive(1'b1, data_word(500 + i), 1'b1);
        drive(1'b1, {2'b11, 30'h2}, 1'b1);
        idle(3, 1'b1);

        // Randomized traffic in phases of differing input density
        for (int ph = 0; ph < 16; ph++) begin
            int vprob;
            int rprob;
            vprob = $urandom_range(10, 100);
            rprob = $urandom_range(0, 100);
            for (int c = 0; c < 200; c++) begin
                logic [31:0] d;
                d = $urandom;
                if ($urandom_range(0, 9) == 0) d[31:30] = 2'b11;
                s_axis_tvalid = ($urandom_range(1, 100) <= vprob);
                s_axis_tdata  = d;
                m_axis_tready = ($urandom_range(1, 100) <= rprob);
                clear_stats   = ($urandom_range(0, 63) == 0);
                areset        = ($urandom_range(0, 499) == 0);
                cycle();
                clear_stats = 1'b0;
                areset      = 1'b0;
            end
        end
        s_axis_tvalid = 1'b0;
        idle(12, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
